// File: rtl/buf_req_sched.sv
// buf_req_sched -- two-requester scheduler in front of an LFU buffer finder.
//
// A winning request is issued to the finder for one cycle, the finder is
// given WAIT_CYC cycles to settle, then the winner receives a one-cycle ack
// carrying the buffer number (its own buffer for a reference, the finder's
// replacement candidate for an allocate).
//
// Optional build macro:
//   BUF_REQ_SCHED_PRIO_EN  - fixed priority (requester 0 wins ties) instead
//                            of round-robin arbitration.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req{0,1}_vld/_new/_buf        request valid, allocate flag, ref buffer
//   req{0,1}_ack                  one-cycle completion pulse
//   rsp_buf                       buffer number, valid while an ack is high
//   lfu_en, lfu_new_req,
//   lfu_ref_req                   finder update enable / request type / buffer
//   lfu_rplc                      finder replacement candidate
//   busy                          scheduler not IDLE
module buf_req_sched #(
    parameter int BUF_BIT  = 2,
    parameter int WAIT_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_vld,
    input  logic               req0_new,
    input  logic [BUF_BIT-1:0] req0_buf,
    input  logic               req1_vld,
    input  logic               req1_new,
    input  logic [BUF_BIT-1:0] req1_buf,
    output logic               req0_ack,
    output logic               req1_ack,
    output logic [BUF_BIT-1:0] rsp_buf,
    output logic               lfu_en,
    output logic               lfu_new_req,
    output logic [BUF_BIT-1:0] lfu_ref_req,
    input  logic [BUF_BIT-1:0] lfu_rplc,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic               win_id, win_id_nxt;     // 0 = requester 0, 1 = requester 1
    logic               win_new, win_new_nxt;
    logic [BUF_BIT-1:0] win_buf, win_buf_nxt;
    logic [BUF_BIT-1:0] resp_q, resp_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic               ack0_nxt, ack1_nxt;
    logic [BUF_BIT-1:0] rsp_buf_nxt;
    logic               lfu_en_nxt, lfu_new_nxt;
    logic [BUF_BIT-1:0] lfu_ref_nxt;
    logic               gnt;                    // requester chosen this cycle
    logic               sel_new;
    logic [BUF_BIT-1:0] sel_buf;

`ifdef BUF_REQ_SCHED_PRIO_EN
    // Requester 0 wins whenever it is asking.
    assign gnt = ~req0_vld;
`else
    // ptr names the requester favoured on a tie; it moves off the last winner.
    logic ptr, ptr_nxt;
    assign gnt = (req0_vld && req1_vld) ? ptr : req1_vld;
`endif

    assign sel_new = gnt ? req1_new : req0_new;
    assign sel_buf = gnt ? req1_buf : req0_buf;

    always_comb begin
        state_nxt   = state;
        win_id_nxt  = win_id;
        win_new_nxt = win_new;
        win_buf_nxt = win_buf;
        resp_nxt    = resp_q;
        cnt_nxt     = cnt;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        rsp_buf_nxt = rsp_buf;
        lfu_en_nxt  = 1'b0;
        lfu_new_nxt = 1'b0;
        lfu_ref_nxt = lfu_ref_req;
`ifndef BUF_REQ_SCHED_PRIO_EN
        ptr_nxt     = ptr;
`endif
        case (state)
            IDLE: begin
                if (req0_vld || req1_vld) begin
                    state_nxt   = ISSUE;
                    win_id_nxt  = gnt;
                    win_new_nxt = sel_new;
                    win_buf_nxt = sel_buf;
                    // Outputs are registered, so the ISSUE-cycle finder drive
                    // is prepared here on the grant edge.
                    lfu_en_nxt  = 1'b1;
                    lfu_new_nxt = sel_new;
                    lfu_ref_nxt = sel_new ? lfu_rplc : sel_buf;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                cnt_nxt   = 3'(WAIT_CYC);
                // Allocate answers with the candidate the finder shows while
                // it is being updated.
                resp_nxt  = win_new ? lfu_rplc : win_buf;
            end
            WAIT: begin
                if (cnt <= 3'd1) begin
                    state_nxt   = RESP;
                    cnt_nxt     = 3'd0;
                    ack0_nxt    = ~win_id;
                    ack1_nxt    = win_id;
                    rsp_buf_nxt = resp_q;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
`ifndef BUF_REQ_SCHED_PRIO_EN
                ptr_nxt   = ~win_id;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win_id      <= 1'b0;
            win_new     <= 1'b0;
            win_buf     <= '0;
            resp_q      <= '0;
            cnt         <= 3'd0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            rsp_buf     <= '0;
            lfu_en      <= 1'b0;
            lfu_new_req <= 1'b0;
            lfu_ref_req <= '0;
            busy        <= 1'b0;
`ifndef BUF_REQ_SCHED_PRIO_EN
            ptr         <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            win_id      <= win_id_nxt;
            win_new     <= win_new_nxt;
            win_buf     <= win_buf_nxt;
            resp_q      <= resp_nxt;
            cnt         <= cnt_nxt;
            req0_ack    <= ack0_nxt;
            req1_ack    <= ack1_nxt;
            rsp_buf     <= rsp_buf_nxt;
            lfu_en      <= lfu_en_nxt;
            lfu_new_req <= lfu_new_nxt;
            lfu_ref_req <= lfu_ref_nxt;
            busy        <= (state_nxt != IDLE);
`ifndef BUF_REQ_SCHED_PRIO_EN
            ptr         <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_buf_req_sched.sv
// Directed bench for buf_req_sched (BUF_BIT=2, WAIT_CYC=2).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_buf_req_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_vld, req0_new, req1_vld, req1_new;
    logic [1:0] req0_buf, req1_buf;
    logic       req0_ack, req1_ack;
    logic [1:0] rsp_buf;
    logic       lfu_en, lfu_new_req;
    logic [1:0] lfu_ref_req, lfu_rplc;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    buf_req_sched #(.BUF_BIT(2), .WAIT_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_new(req0_new), .req0_buf(req0_buf),
        .req1_vld(req1_vld), .req1_new(req1_new), .req1_buf(req1_buf),
        .req0_ack(req0_ack), .req1_ack(req1_ack), .rsp_buf(rsp_buf),
        .lfu_en(lfu_en), .lfu_new_req(lfu_new_req), .lfu_ref_req(lfu_ref_req),
        .lfu_rplc(lfu_rplc), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".acks"}, {req1_ack, req0_ack}, 2'b00);
        chk({tag, ".lfu_en"}, lfu_en, 1'b0);
        chk({tag, ".lfu_new"}, lfu_new_req, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
    endtask

    // One isolated request from requester id; expects ack 4 cycles after grant.
    task automatic txn(input string tag, input bit id, input bit nw,
                       input logic [1:0] b, input logic [1:0] exp_buf);
        @(negedge clk);
        if (id) begin req1_vld = 1; req1_new = nw; req1_buf = b; end
        else    begin req0_vld = 1; req0_new = nw; req0_buf = b; end
        @(negedge clk);                               // ISSUE
        chk({tag, ".issue_en"}, lfu_en, 1'b1);
        chk({tag, ".issue_new"}, lfu_new_req, nw);
        chk({tag, ".issue_ref"}, lfu_ref_req, exp_buf);
        chk({tag, ".issue_busy"}, busy, 1'b1);
        @(negedge clk);                               // WAIT 1
        chk({tag, ".wait_en"}, lfu_en, 1'b0);
        chk({tag, ".wait_ref_hold"}, lfu_ref_req, exp_buf);
        chk({tag, ".wait1_acks"}, {req1_ack, req0_ack}, 2'b00);
        @(negedge clk);                               // WAIT 2
        chk({tag, ".wait2_acks"}, {req1_ack, req0_ack}, 2'b00);
        @(negedge clk);                               // RESP
        chk({tag, ".resp_acks"}, {req1_ack, req0_ack}, id ? 2'b10 : 2'b01);
        chk({tag, ".resp_buf"}, rsp_buf, exp_buf);
        req0_vld = 0; req1_vld = 0;
        @(negedge clk);                               // IDLE
        chk_idle({tag, ".after"});
    endtask

    initial begin
        logic [1:0] rr_exp;
        rst_n = 0; req0_vld = 0; req1_vld = 0; req0_new = 0; req1_new = 0;
        req0_buf = 0; req1_buf = 0; lfu_rplc = 0;

        // Reset and quiet idle.
        repeat (2) @(negedge clk);
        chk_idle("rst");
        chk("rst.rsp_buf", rsp_buf, 2'd0);
        chk("rst.ref", lfu_ref_req, 2'd0);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk_idle("quiet");

        // Reference by requester 0, then allocate by requester 1.
        txn("ref0", 1'b0, 1'b0, 2'd2, 2'd2);
        lfu_rplc = 2'd3;
        txn("alloc1", 1'b1, 1'b1, 2'd0, 2'd3);

        // Both held: round-robin alternates, fixed priority keeps requester 0.
        @(negedge clk);
        req0_vld = 1; req0_new = 0; req0_buf = 2'd1;
        req1_vld = 1; req1_new = 0; req1_buf = 2'd2;
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(negedge clk);
`ifdef BUF_REQ_SCHED_PRIO_EN
            rr_exp = 2'b01;
`else
            rr_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk($sformatf("rr%0d.acks", k), {req1_ack, req0_ack}, rr_exp);
            chk($sformatf("rr%0d.buf", k), rsp_buf, rr_exp[1] ? 2'd2 : 2'd1);
            if (k == 3) begin req0_vld = 0; req1_vld = 0; end
            @(negedge clk);
            chk($sformatf("rr%0d.gap", k), {req1_ack, req0_ack}, 2'b00);
        end
        @(negedge clk);
        chk_idle("rr.end");

        // Winner drops vld during WAIT; late requester waits for IDLE.
        req0_vld = 1; req0_new = 0; req0_buf = 2'd1;
        @(negedge clk);
        chk("drop.issue_ref", lfu_ref_req, 2'd1);
        @(negedge clk);
        req0_vld = 0; req1_vld = 1; req1_new = 0; req1_buf = 2'd0;
        @(negedge clk);
        chk("drop.wait_acks", {req1_ack, req0_ack}, 2'b00);
        chk("drop.wait_en", lfu_en, 1'b0);
        @(negedge clk);
        chk("drop.acks", {req1_ack, req0_ack}, 2'b01);
        chk("drop.buf", rsp_buf, 2'd1);
        @(negedge clk);
        chk("late.idle_busy", busy, 1'b0);
        chk("late.idle_en", lfu_en, 1'b0);
        @(negedge clk);
        chk("late.issue_en", lfu_en, 1'b1);
        chk("late.issue_ref", lfu_ref_req, 2'd0);
        repeat (3) @(negedge clk);
        chk("late.acks", {req1_ack, req0_ack}, 2'b10);
        chk("late.buf", rsp_buf, 2'd0);
        req1_vld = 0;
        @(negedge clk);
        chk_idle("late.after");

        // Leave requester 0 as last winner, then reset during WAIT.
        txn("pre_rst", 1'b0, 1'b0, 2'd2, 2'd2);
        @(negedge clk);
        req0_vld = 1; req0_new = 0; req0_buf = 2'd3;
        @(negedge clk);
        chk("inflight.issue_ref", lfu_ref_req, 2'd3);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk_idle("midrst");
        chk("midrst.rsp_buf", rsp_buf, 2'd0);
        chk("midrst.ref", lfu_ref_req, 2'd0);
        req0_vld = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk_idle("postrst.quiet");

        // Pointer is back at requester 0: it wins the tie.
        req0_vld = 1; req0_new = 0; req0_buf = 2'd1;
        req1_vld = 1; req1_new = 0; req1_buf = 2'd2;
        @(negedge clk);
        chk("postrst.issue_ref", lfu_ref_req, 2'd1);
        repeat (3) @(negedge clk);
        chk("postrst.acks", {req1_ack, req0_ack}, 2'b01);
        chk("postrst.buf", rsp_buf, 2'd1);
        req0_vld = 0;
        repeat (5) @(negedge clk);
        chk("postrst1.acks", {req1_ack, req0_ack}, 2'b10);
        chk("postrst1.buf", rsp_buf, 2'd2);
        req1_vld = 0;
        @(negedge clk);
        chk_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
